// File: rtl/vga_sync_monitor_if.sv
// Bus between a VGA timing source and vga_sync_monitor.
// master: the side that drives sync/RGB and reads the recovered timing.
// slave : the monitor itself.
interface vga_sync_monitor_if;
  logic        hsync;
  logic        vsync;
  logic [2:0]  red;
  logic [2:0]  green;
  logic [1:0]  blue;
  logic        err_clr;
  logic [10:0] x;
  logic [9:0]  y;
  logic [7:0]  pix_rgb;
  logic        active;
  logic        locked;
  logic        frame_done;
  logic [3:0]  err_flags;
  logic [15:0] frame_crc;
  logic        crc_valid;

  modport master (
    output hsync, vsync, red, green, blue, err_clr,
    input  x, y, pix_rgb, active, locked, frame_done, err_flags, frame_crc, crc_valid
  );

  modport slave (
    input  hsync, vsync, red, green, blue, err_clr,
    output x, y, pix_rgb, active, locked, frame_done, err_flags, frame_crc, crc_valid
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: recovers (x, y) from observed hsync/vsync, checks line and
// frame timing, runs a SEARCH/ACQUIRE/LOCKED lock machine and keeps sticky
// timing error flags.
// Optional feature macro: FRAME_CRC_EN (CRC-16-CCITT over each frame's active pixels).
module vga_sync_monitor #(
  parameter int HPIXELS     = 800,
  parameter int HPULSE      = 96,
  parameter int VLINES      = 521,
  parameter int VPULSE      = 2,
  parameter int HBP         = 144,
  parameter int HFP         = 784,
  parameter int VBP         = 31,
  parameter int VFP         = 511,
  parameter int LOCK_FRAMES = 2
) (
  input logic               clk_vga,
  input logic               rst,
  vga_sync_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  logic        hs_q, vs_q, hs_p, vs_p;
  logic [7:0]  rgb_q, rgb_p;
  logic        fall_h, rise_h, fall_v, rise_v;

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [10:0] hw_cnt_q, hw_cnt_d;
  logic        h_seen_q, h_seen_d;
  logic        v_seen_q, v_seen_d;
  logic [3:0]  err_q, err_d;
  logic        frame_err_q, frame_err_d;
  logic        frame_done_q, frame_done_d;
  logic [3:0]  raised;
  logic        any_err;
  logic        enter_search;

  state_e      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic        locked;
  logic        active;

  // Two-stage capture of the raw inputs; the pair of stages gives edge detection.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      rgb_q <= '0;
      hs_p  <= 1'b0;
      vs_p  <= 1'b0;
      rgb_p <= '0;
    end else begin
      hs_q  <= bus.hsync;
      vs_q  <= bus.vsync;
      rgb_q <= {bus.red, bus.green, bus.blue};
      hs_p  <= hs_q;
      vs_p  <= vs_q;
      rgb_p <= rgb_q;
    end
  end

  assign fall_h = hs_p & ~hs_q;
  assign rise_h = ~hs_p & hs_q;
  assign fall_v = vs_p & ~vs_q;
  assign rise_v = ~vs_p & vs_q;

  // Timing checks; each is suppressed until the first matching sync edge so a
  // partial line or frame after reset or loss of lock is never reported.
  always_comb begin
    raised = '0;
    if (fall_h && h_seen_q && (int'(h_cnt_q) + 1 != HPIXELS)) raised[0] = 1'b1;
    if (!fall_h && h_seen_q && (h_cnt_q == 11'd2046))         raised[0] = 1'b1;
    if (rise_h && h_seen_q && (int'(hw_cnt_q) != HPULSE))     raised[1] = 1'b1;
    if (fall_v && v_seen_q && (int'(v_cnt_q) + 1 != VLINES))  raised[2] = 1'b1;
    if (rise_v && v_seen_q && (int'(v_cnt_q) + 1 != VPULSE))  raised[3] = 1'b1;
  end

  assign any_err      = |raised;
  assign enter_search = (state_q == LOCKED) && any_err;

  // Next values for the position counters, pulse-width counter and error state.
  always_comb begin
    if (fall_h)                    h_cnt_d = '0;
    else if (h_cnt_q == 11'h7FF)   h_cnt_d = h_cnt_q;
    else                           h_cnt_d = h_cnt_q + 11'd1;

    v_cnt_d = v_cnt_q;
    if (fall_v)                    v_cnt_d = '0;
    else if (fall_h && (v_cnt_q != 10'h3FF)) v_cnt_d = v_cnt_q + 10'd1;

    if (hs_q)                      hw_cnt_d = '0;
    else if (hw_cnt_q == 11'h7FF)  hw_cnt_d = hw_cnt_q;
    else                           hw_cnt_d = hw_cnt_q + 11'd1;

    h_seen_d = enter_search ? 1'b0 : (h_seen_q | fall_h);
    v_seen_d = enter_search ? 1'b0 : (v_seen_q | fall_v);

    err_d        = bus.err_clr ? raised : (err_q | raised);
    frame_err_d  = fall_v ? 1'b0 : (frame_err_q | any_err);
    frame_done_d = fall_v;
  end

  // Datapath registers.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      hw_cnt_q     <= '0;
      h_seen_q     <= 1'b0;
      v_seen_q     <= 1'b0;
      err_q        <= '0;
      frame_err_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      hw_cnt_q     <= hw_cnt_d;
      h_seen_q     <= h_seen_d;
      v_seen_q     <= v_seen_d;
      err_q        <= err_d;
      frame_err_q  <= frame_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Lock machine state register.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Lock machine next state: count clean frames in ACQUIRE, fall back on any error in LOCKED.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        if (fall_v) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (fall_v) begin
          if (frame_err_q || any_err) begin
            good_d = '0;
          end else if (int'(good_q) + 1 >= LOCK_FRAMES) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
      end
      LOCKED: begin
        if (any_err) state_d = SEARCH;
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase
  end

  // Lock machine outputs: lock status and the active-region window.
  always_comb begin
    locked = (state_q == LOCKED);
    active = locked &&
             (int'(h_cnt_q) >= HBP) && (int'(h_cnt_q) < HFP) &&
             (int'(v_cnt_q) >= VBP) && (int'(v_cnt_q) < VFP);
  end

  assign bus.x          = h_cnt_q;
  assign bus.y          = v_cnt_q;
  assign bus.pix_rgb    = rgb_p;
  assign bus.active     = active;
  assign bus.locked     = locked;
  assign bus.frame_done = frame_done_q;
  assign bus.err_flags  = err_q;

`ifdef FRAME_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic [15:0] frame_crc_q, frame_crc_d;
  logic        crc_valid_q, crc_valid_d;

  function automatic logic [15:0] crcStep(input logic [15:0] crcIn, input logic [7:0] data);
    logic [15:0] c;
    c = crcIn;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Running CRC over active pixels; snapshot and restart at every frame boundary.
  always_comb begin
    crc_d       = crc_q;
    frame_crc_d = frame_crc_q;
    crc_valid_d = 1'b0;
    if (fall_v) begin
      frame_crc_d = crc_q;
      crc_valid_d = 1'b1;
      crc_d       = 16'hFFFF;
    end else if (active) begin
      crc_d = crcStep(crc_q, rgb_p);
    end
  end

  // CRC registers.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      crc_q       <= '0;
      frame_crc_q <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign bus.frame_crc = frame_crc_q;
  assign bus.crc_valid = crc_valid_q;
`else
  assign bus.frame_crc = '0;
  assign bus.crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down 40x12 raster so that
// many frames fit in a short run. A behavioural timing source is stepped one
// clock at a time and outputs are sampled 1 time unit after the rising edge.
module tb_vga_sync_monitor;

  localparam int HP  = 40;
  localparam int HPU = 4;
  localparam int VL  = 12;
  localparam int VP  = 2;
  localparam int HB  = 8;
  localparam int HF  = 36;
  localparam int VB  = 3;
  localparam int VF  = 11;
  localparam int LF  = 2;

  logic clk_vga = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  int hc = 0, vc = 0;
  int curLen = HP, curHpw = HPU, curLines = VL, curVpw = VP;
  bit extraLine = 0, shortPulse = 0, shortFrame = 0, longVsync = 0;
  int patMode = 1;
  int pokeX = -1, pokeY = -1;
  logic [7:0] expPix;
  logic [15:0] zeroCrc;

  vga_sync_monitor_if bus ();

  vga_sync_monitor #(
    .HPIXELS(HP), .HPULSE(HPU), .VLINES(VL), .VPULSE(VP),
    .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .LOCK_FRAMES(LF)
  ) dut (
    .clk_vga(clk_vga),
    .rst(rst),
    .bus(bus)
  );

  // 10-unit VGA clock.
  always #5 clk_vga = ~clk_vga;

  // Pixel value the source drives at a given source coordinate.
  function automatic logic [7:0] pattern(input int px, input int py);
    if (patMode == 0) return (px == pokeX && py == pokeY) ? 8'hA5 : 8'h00;
    return 8'((px * 7 + py * 13) & 255);
  endfunction

  // Reference CRC-16-CCITT of n zero bytes, computed bit by bit.
  function automatic logic [15:0] crcOfZeros(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < n * 8; k++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // One clock of the timing source: drive (hc, vc), wait for the edge, advance.
  task automatic applyStimulus();
    if (hc == 0) begin
      if (vc == 0) begin
        curLines   = shortFrame ? VL - 1 : VL;
        curVpw     = longVsync ? VP + 1 : VP;
        shortFrame = 0;
        longVsync  = 0;
      end
      curLen     = extraLine ? HP + 1 : HP;
      curHpw     = shortPulse ? HPU - 1 : HPU;
      extraLine  = 0;
      shortPulse = 0;
    end
    bus.hsync = (hc >= curHpw);
    bus.vsync = (vc >= curVpw);
    {bus.red, bus.green, bus.blue} = pattern(hc, vc);
    @(posedge clk_vga);
    #1;
    hc++;
    if (hc == curLen) begin
      hc = 0;
      vc++;
      if (vc == curLines) vc = 0;
    end
  endtask

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step the source until it is about to drive (tx, ty); always steps at least once.
  task automatic runTo(input int tx, input int ty);
    int n;
    n = 0;
    applyStimulus();
    while (!(hc == tx && vc == ty) && n < 2000) begin
      applyStimulus();
      n++;
    end
    if (n >= 2000) checkOutput("runTo_reach", {16'(hc), 16'(vc)}, {16'(tx), 16'(ty)});
  endtask

  // Drive source pixel (px, py) and check the recovered coordinate two clocks later.
  task automatic probe(input int px, input int py, input logic expActive);
    runTo(px, py);
    expPix = pattern(px, py);
    applyStimulus();
    applyStimulus();
    checkOutput("probe_x", 32'(bus.x), 32'(px));
    checkOutput("probe_y", 32'(bus.y), 32'(py));
    checkOutput("probe_pix", 32'(bus.pix_rgb), 32'(expPix));
    checkOutput("probe_active", 32'(bus.active), 32'(expActive));
  endtask

  // Directed sequence.
  initial begin
    rst         = 1'b1;
    bus.hsync   = 1'b1;
    bus.vsync   = 1'b1;
    bus.red     = '0;
    bus.green   = '0;
    bus.blue    = '0;
    bus.err_clr = 1'b0;
    zeroCrc     = crcOfZeros((HF - HB) * (VF - VB));
    repeat (3) @(posedge clk_vga);
    #1;
    checkOutput("rst_x", 32'(bus.x), 0);
    checkOutput("rst_y", 32'(bus.y), 0);
    checkOutput("rst_err", 32'(bus.err_flags), 0);
    checkOutput("rst_locked", 32'(bus.locked), 0);
    checkOutput("rst_frame_done", 32'(bus.frame_done), 0);
    checkOutput("rst_active", 32'(bus.active), 0);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk_vga);
      #1;
    end

    $display("[TB] nominal timing, acquire and lock");
    runTo(0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("acq1_locked", 32'(bus.locked), 0);
    runTo(0, 0);
    applyStimulus();
    checkOutput("prelock_locked", 32'(bus.locked), 0);
    applyStimulus();
    checkOutput("lock_locked", 32'(bus.locked), 1);
    checkOutput("lock_frame_done", 32'(bus.frame_done), 1);
    applyStimulus();
    checkOutput("frame_done_pulse", 32'(bus.frame_done), 0);
    checkOutput("lock_err", 32'(bus.err_flags), 0);

    probe(HB, VB, 1'b1);
    probe(20, 5, 1'b1);
    probe(38, 5, 1'b0);
    probe(HF - 1, VF - 1, 1'b1);
    probe(HF, VF - 1, 1'b0);
    probe(20, VF, 1'b0);

    $display("[TB] one long line while locked");
    runTo(0, 6);
    extraLine = 1;
    runTo(0, 7);
    applyStimulus();
    checkOutput("long_err_before", 32'(bus.err_flags), 0);
    checkOutput("long_locked_before", 32'(bus.locked), 1);
    applyStimulus();
    checkOutput("long_err", 32'(bus.err_flags), 32'h1);
    checkOutput("long_locked", 32'(bus.locked), 0);
    runTo(0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("relock_f1", 32'(bus.locked), 0);
    runTo(0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("relock_f2", 32'(bus.locked), 0);
    runTo(0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("relock_f3", 32'(bus.locked), 1);
    checkOutput("relock_err_sticky", 32'(bus.err_flags), 32'h1);

    $display("[TB] short hsync pulse with coincident and plain err_clr");
    runTo(0, 2);
    shortPulse = 1;
    runTo(HPU - 1, 2);
    applyStimulus();
    checkOutput("hw_err_before", 32'(bus.err_flags), 32'h1);
    bus.err_clr = 1'b1;
    applyStimulus();
    bus.err_clr = 1'b0;
    checkOutput("hw_err_wins_clr", 32'(bus.err_flags), 32'h2);
    checkOutput("hw_locked", 32'(bus.locked), 0);
    bus.err_clr = 1'b1;
    applyStimulus();
    bus.err_clr = 1'b0;
    checkOutput("err_clr", 32'(bus.err_flags), 0);

    $display("[TB] short frame and long vsync");
    runTo(0, 0);
    shortFrame = 1;
    applyStimulus();
    longVsync = 1;
    runTo(0, 0);
    applyStimulus();
    checkOutput("frame_err_before", 32'(bus.err_flags), 0);
    applyStimulus();
    checkOutput("frame_err", 32'(bus.err_flags), 32'h4);
    runTo(0, 3);
    applyStimulus();
    checkOutput("vw_err_before", 32'(bus.err_flags), 32'h4);
    applyStimulus();
    checkOutput("vw_err", 32'(bus.err_flags), 32'hC);

    $display("[TB] reset mid-frame");
    runTo(20, 6);
    applyStimulus();
    applyStimulus();
    checkOutput("prereset_x", 32'(bus.x), 20);
    rst = 1'b1;
    #1;
    checkOutput("midrst_x", 32'(bus.x), 0);
    checkOutput("midrst_y", 32'(bus.y), 0);
    checkOutput("midrst_err", 32'(bus.err_flags), 0);
    checkOutput("midrst_locked", 32'(bus.locked), 0);
    checkOutput("midrst_pix", 32'(bus.pix_rgb), 0);
    repeat (4) applyStimulus();
    checkOutput("midrst_hold_x", 32'(bus.x), 0);
    rst = 1'b0;
    runTo(0, 0);
    runTo(0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("postrst_acq", 32'(bus.locked), 0);
    runTo(0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("postrst_locked", 32'(bus.locked), 1);
    checkOutput("postrst_err", 32'(bus.err_flags), 0);
    patMode = 0;

`ifdef FRAME_CRC_EN
    $display("[TB] frame CRC");
    runTo(0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("crc_valid1", 32'(bus.crc_valid), 1);
    checkOutput("crc_zero1", 32'(bus.frame_crc), 32'(zeroCrc));
    applyStimulus();
    checkOutput("crc_valid_pulse", 32'(bus.crc_valid), 0);
    runTo(0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("crc_zero2", 32'(bus.frame_crc), 32'(zeroCrc));
    pokeX = 20;
    pokeY = 5;
    runTo(0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("crc_poked_differs", 32'(bus.frame_crc == zeroCrc), 0);
    pokeX = -1;
    pokeY = -1;
    runTo(0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("crc_zero3", 32'(bus.frame_crc), 32'(zeroCrc));
`else
    runTo(0, 0);
    applyStimulus();
    applyStimulus();
    checkOutput("nocrc_frame_done", 32'(bus.frame_done), 1);
    checkOutput("nocrc_valid", 32'(bus.crc_valid), 0);
    checkOutput("nocrc_value", 32'(bus.frame_crc), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
